// File: rtl/snake_pkg.sv
// Shared playfield constants and FSM state encodings for the snake game blocks.
package snake_pkg;

  localparam int unsigned CELL_W        = 9;
  localparam int unsigned CELLS_DEFAULT = 480;
  localparam int unsigned SCAN_W        = 10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRAW  = 2'd1;
  localparam state_t ST_QWAIT = 2'd2;
  localparam state_t ST_SCAN  = 2'd3;

endpackage

// File: rtl/food_spawner.sv
// Turns PRNG draws into a free food cell, falling back to a linear scan after
// MAX_TRIES failed draws so placement always terminates.
module food_spawner
  import snake_pkg::*;
#(
  parameter int unsigned CELLS     = CELLS_DEFAULT,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CELL_W-1:0] i_rng,
  input  logic              i_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [CELL_W-1:0] o_pos,
  output logic              o_grid_full,
  output logic              o_q_valid,
  output logic [CELL_W-1:0] o_q_idx,
  input  logic              i_q_occ
);

  localparam int unsigned       TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]  TRY_MAX  = TRY_W'(MAX_TRIES);
  localparam logic [SCAN_W-1:0] CELLS_X  = SCAN_W'(CELLS);
  localparam logic [CELL_W-1:0] LAST_IDX = CELL_W'(CELLS - 1);

  state_t              state_q, state_d;
  logic                scan_q, scan_d;
  logic [CELL_W-1:0]   idx_q, idx_d;
  logic [TRY_W-1:0]    tries_q, tries_d;
  logic [SCAN_W-1:0]   scanned_q, scanned_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                full_q, full_d;
  logic                qv_q, qv_d;
  logic [CELL_W-1:0]   qidx_q, qidx_d;
  logic [CELL_W-1:0]   pos_q, pos_d;

  logic                rng_ok;
  logic [TRY_W-1:0]    tries_inc;
  logic [SCAN_W-1:0]   scanned_inc;
  logic [CELL_W-1:0]   idx_wrap;

  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    idx_d     = idx_q;
    tries_d   = tries_q;
    scanned_d = scanned_q;
    pos_d     = pos_q;
    qidx_d    = qidx_q;
    qv_d      = 1'b0;
    done_d    = 1'b0;
    full_d    = 1'b0;

    rng_ok      = ({1'b0, i_rng} < CELLS_X);
    tries_inc   = tries_q + TRY_W'(1);
    scanned_inc = scanned_q + SCAN_W'(1);
    idx_wrap    = (idx_q == LAST_IDX) ? '0 : idx_q + CELL_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          tries_d   = '0;
          scanned_d = '0;
          idx_d     = '0;
          scan_d    = 1'b0;
          state_d   = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (rng_ok) begin
          idx_d   = i_rng;
          qv_d    = 1'b1;
          qidx_d  = i_rng;
          state_d = ST_QWAIT;
        end else begin
          tries_d = tries_inc;
          state_d = (tries_inc == TRY_MAX) ? ST_SCAN : ST_DRAW;
        end
      end
      ST_QWAIT: begin
        // Occupancy of the cell queried on the previous edge is decided here.
        if (!i_q_occ) begin
          pos_d   = idx_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (scan_q) begin
          scanned_d = scanned_inc;
          if (scanned_inc == CELLS_X) begin
            full_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SCAN;
          end
        end else begin
          tries_d = tries_inc;
          state_d = (tries_inc == TRY_MAX) ? ST_SCAN : ST_DRAW;
        end
      end
      ST_SCAN: begin
        idx_d   = idx_wrap;
        qv_d    = 1'b1;
        qidx_d  = idx_wrap;
        scan_d  = 1'b1;
        state_d = ST_QWAIT;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      scan_q    <= 1'b0;
      idx_q     <= '0;
      tries_q   <= '0;
      scanned_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      qv_q      <= 1'b0;
      qidx_q    <= '0;
      pos_q     <= '0;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      idx_q     <= idx_d;
      tries_q   <= tries_d;
      scanned_q <= scanned_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      full_q    <= full_d;
      qv_q      <= qv_d;
      qidx_q    <= qidx_d;
      pos_q     <= pos_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_pos       = pos_q;
  assign o_grid_full = full_q;
  assign o_q_valid   = qv_q;
  assign o_q_idx     = qidx_q;

endmodule

// File: tb/tb_food_spawner.sv
// Bench for food_spawner: per-request timeline model of draws and scan steps,
// checked every cycle, plus directed latency/position/grid-full scenarios.
module tb_food_spawner;
  import snake_pkg::*;

  localparam int C    = 480;
  localparam int MT   = 4;
  localparam int NCYC = 32768;

  logic              clk, rst_n, i_req, i_q_occ;
  logic [CELL_W-1:0] i_rng;
  logic              o_busy, o_done, o_grid_full, o_q_valid;
  logic [CELL_W-1:0] o_pos, o_q_idx;

  logic [CELL_W-1:0] rng_tab [NCYC];
  bit                req_tab [NCYC];
  bit                e_qv [NCYC];
  bit                e_done [NCYC];
  bit                e_full [NCYC];
  bit                e_busy [NCYC];
  logic [CELL_W-1:0] e_qidx [NCYC];
  logic [CELL_W-1:0] e_pos [NCYC];
  bit                occ [512];

  int                cyc = 0;
  int                checks = 0;
  int                errors = 0;
  bit                chk_en = 1'b0;
  logic [CELL_W-1:0] ref_pos = '0;
  int                done_cnt, full_cnt, qv_cnt, busy_cnt, done_cyc, full_cyc;
  logic [CELL_W-1:0] done_pos;

  food_spawner #(.CELLS(C), .MAX_TRIES(MT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rng       (i_rng),
    .i_req       (i_req),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_pos       (o_pos),
    .o_grid_full (o_grid_full),
    .o_q_valid   (o_q_valid),
    .o_q_idx     (o_q_idx),
    .i_q_occ     (i_q_occ)
  );

  // Occupancy store answers the currently presented query index.
  assign i_q_occ = occ[o_q_idx];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc + 1 < NCYC) begin
      i_rng = rng_tab[cyc + 1];
      i_req = req_tab[cyc + 1];
    end else begin
      i_rng = '0;
      i_req = 1'b0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) ref_pos = '0;
    if (o_done) begin done_cnt++; done_cyc = cyc; done_pos = o_pos; end
    if (o_grid_full) begin full_cnt++; full_cyc = cyc; end
    if (o_q_valid) qv_cnt++;
    if (o_busy) busy_cnt++;
    if (chk_en && cyc < NCYC) begin
      if (e_done[cyc]) ref_pos = e_pos[cyc];
      chk("busy", int'(o_busy), int'(e_busy[cyc]));
      chk("done", int'(o_done), int'(e_done[cyc]));
      chk("grid_full", int'(o_grid_full), int'(e_full[cyc]));
      chk("q_valid", int'(o_q_valid), int'(e_qv[cyc]));
      if (e_qv[cyc]) chk("q_idx", int'(o_q_idx), int'(e_qidx[cyc]));
      chk("pos", int'(o_pos), int'(ref_pos));
    end
  end

  // Timeline model: request sampled at edge e0; out-of-range draw costs one edge,
  // an in-range draw or scan step costs a query edge plus a decision edge.
  task automatic model(input int e0, output int end_e);
    int t, tries, scanned, idx, v;
    bit scan, fin;
    t = e0 + 1; tries = 0; scanned = 0; idx = 0; scan = 1'b0; fin = 1'b0; end_e = 0;
    while (!fin) begin
      if (t >= NCYC - 8) begin
        $display("FAIL model_overflow cyc=%0d got=%0d expected<%0d", cyc, t, NCYC - 8);
        $fatal(1);
      end
      if (!scan) begin
        v = int'(rng_tab[t]);
        if (v < C) begin
          e_qv[t] = 1'b1; e_qidx[t] = CELL_W'(v); idx = v;
          if (!occ[v]) begin
            end_e = t + 1; e_done[t + 1] = 1'b1; e_pos[t + 1] = CELL_W'(v); fin = 1'b1;
          end else begin
            tries++; t += 2;
          end
        end else begin
          tries++; t += 1;
        end
        if (tries == MT) scan = 1'b1;
      end else begin
        idx = (idx + 1) % C;
        e_qv[t] = 1'b1; e_qidx[t] = CELL_W'(idx);
        if (!occ[idx]) begin
          end_e = t + 1; e_done[t + 1] = 1'b1; e_pos[t + 1] = CELL_W'(idx); fin = 1'b1;
        end else begin
          scanned++;
          if (scanned == C) begin
            end_e = t + 1; e_full[t + 1] = 1'b1; fin = 1'b1;
          end else begin
            t += 2;
          end
        end
      end
    end
    for (int k = e0; k < end_e; k++) e_busy[k] = 1'b1;
  endtask

  task automatic plan_req(input int gap, output int e0, output int end_e);
    e0 = cyc + 1 + gap;
    model(e0, end_e);
    req_tab[e0] = 1'b1;
    for (int k = e0 + 1; k <= end_e; k++) req_tab[k] = bit'($urandom_range(0, 1));
  endtask

  task automatic run_req(input int gap, output int e0);
    int end_e;
    plan_req(gap, e0, end_e);
    while (cyc < end_e) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic clr_cnt();
    done_cnt = 0; full_cnt = 0; qv_cnt = 0; busy_cnt = 0; done_cyc = -1; full_cyc = -1;
  endtask

  task automatic set_occ(input bit val);
    for (int i = 0; i < 512; i++) occ[i] = val;
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  initial begin
    int e0, end_e, d, r;
    int dens [4] = '{0, 30, 90, 99};
    rst_n = 1'b1;
    i_req = 1'b0;
    i_rng = '0;
    for (int k = 0; k < NCYC; k++) begin
      r = int'($urandom_range(0, 99));
      rng_tab[k] = (r < 30) ? CELL_W'($urandom_range(480, 511)) : CELL_W'($urandom_range(0, 479));
    end
    set_occ(1'b0);
    chk_en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_q_valid", int'(o_q_valid), 0);
    chk("rst_pos", int'(o_pos), 0);
    chk("rst_q_idx", int'(o_q_idx), 0);
    rst_n = 1'b1;
    settle();

    // Best case on an empty board.
    clr_cnt();
    rng_tab[cyc + 2] = 9'd37;
    run_req(0, e0); settle();
    chk("t1_latency", done_cyc - e0, 2);
    chk("t1_pos", int'(done_pos), 37);
    chk("t1_busy_cycles", busy_cnt, 2);
    chk("t1_queries", qv_cnt, 1);

    // One out-of-range draw adds a single cycle.
    clr_cnt();
    rng_tab[cyc + 2] = 9'd500; rng_tab[cyc + 3] = 9'd100;
    run_req(0, e0); settle();
    chk("t2_latency", done_cyc - e0, 3);
    chk("t2_pos", int'(done_pos), 100);
    chk("t2_queries", qv_cnt, 1);

    // Three occupied draws then a free one.
    clr_cnt();
    occ[10] = 1'b1; occ[20] = 1'b1; occ[30] = 1'b1;
    rng_tab[cyc + 2] = 9'd10; rng_tab[cyc + 4] = 9'd20;
    rng_tab[cyc + 6] = 9'd30; rng_tab[cyc + 8] = 9'd40;
    run_req(0, e0); settle();
    chk("t3_latency", done_cyc - e0, 8);
    chk("t3_pos", int'(done_pos), 40);
    chk("t3_queries", qv_cnt, 4);

    // Draws exhausted, scan wraps from 471 round to free cell 5.
    clr_cnt();
    set_occ(1'b1); occ[5] = 1'b0;
    for (int k = 1; k <= 40; k++) rng_tab[cyc + 1 + k] = 9'd470;
    run_req(0, e0); settle();
    chk("t4_latency", done_cyc - e0, 38);
    chk("t4_pos", int'(done_pos), 5);
    chk("t4_queries", qv_cnt, 19);
    chk("t4_full", full_cnt, 0);

    // Full board: exactly one grid-full pulse, no done.
    clr_cnt();
    set_occ(1'b1);
    for (int k = 1; k <= 8; k++) rng_tab[cyc + 1 + k] = 9'd100;
    run_req(0, e0); settle();
    chk("t5_full_cnt", full_cnt, 1);
    chk("t5_full_latency", full_cyc - e0, 968);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_queries", qv_cnt, 484);
    chk("t5_idle_busy", int'(o_busy), 0);

    // Asynchronous reset in the middle of a scan.
    clr_cnt();
    plan_req(0, e0, end_e);
    repeat (50) @(posedge clk);
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t6_busy_drop", int'(o_busy), 0);
    chk("t6_qv_drop", int'(o_q_valid), 0);
    for (int k = cyc; k < NCYC; k++) begin
      e_qv[k] = 1'b0; e_done[k] = 1'b0; e_full[k] = 1'b0; e_busy[k] = 1'b0; req_tab[k] = 1'b0;
    end
    done_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk("t6_no_done", done_cnt, 0);
    chk("t6_pos_cleared", int'(o_pos), 0);
    chk_en = 1'b1;
    set_occ(1'b0);
    clr_cnt();
    run_req(1, e0); settle();
    chk("t6_after_done", done_cnt, 1);

    // Randomized requests over varied occupancy densities.
    for (int n = 0; n < 30; n++) begin
      d = dens[$urandom_range(0, 3)];
      for (int i = 0; i < 512; i++) occ[i] = (int'($urandom_range(0, 99)) < d);
      run_req(int'($urandom_range(0, 3)), e0);
    end
    repeat (4) settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
